// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_ctrl
//  Purpose  : Arbitrates fetch (IF) and data (D) requests onto a single
//             asynchronous SRAM. It sequences the MAR/MDR load strobes and
//             holds the SRAM strobes for WAIT_CYCLES cycles.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic IF_Req,
  input  logic D_Req,
  input  logic D_WE,
  output logic IF_Done,
  output logic D_Done,
  output logic ADDR_Sel,
  output logic LD_MAR,
  output logic LD_MDR,
  output logic MIO_EN,
  output logic Mem_OE_N,
  output logic Mem_WE_N,
  output logic Busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    RD_WAIT = 3'd2,
    WR_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       owner_d;    // 1: data port owns the access, 0: fetch port
  logic       is_write;   // latched direction; always 0 for fetch accesses
  logic       pref_d;     // round-robin pointer: 1 means D wins a tie

  logic       grant_d;

  // Tie goes to the port that lost the previous grant; a lone request always wins
  always_comb begin
    grant_d = D_Req && (!IF_Req || pref_d);
  end

  // Access sequencer: state, owner/direction latch, wait counter, arbitration pointer
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      owner_d  <= 1'b0;
      is_write <= 1'b0;
      pref_d   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (IF_Req || D_Req) begin
            owner_d  <= grant_d;
            is_write <= grant_d && D_WE;
            pref_d   <= !grant_d;
            state    <= ADDR;
          end
        end
        ADDR: begin
          cnt   <= CNT_LOAD;
          state <= is_write ? WR_WAIT : RD_WAIT;
        end
        RD_WAIT, WR_WAIT: begin
          if (cnt == 4'd0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Output decode from registered state only, so reset releases every strobe at once
  always_comb begin
    IF_Done  = 1'b0;
    D_Done   = 1'b0;
    LD_MAR   = 1'b0;
    LD_MDR   = 1'b0;
    MIO_EN   = 1'b0;
    Mem_OE_N = 1'b1;
    Mem_WE_N = 1'b1;
    Busy     = (state != IDLE);
    ADDR_Sel = owner_d;
    case (state)
      ADDR: begin
        LD_MAR = 1'b1;
        // A write loads bus data into the MDR now (MIO_EN stays 0 to select the bus)
        LD_MDR = is_write;
      end
      RD_WAIT: begin
        Mem_OE_N = 1'b0;
        // Capture SRAM read data only on the last strobe cycle
        if (cnt == 4'd0) begin
          LD_MDR = 1'b1;
          MIO_EN = 1'b1;
        end
      end
      WR_WAIT: begin
        Mem_WE_N = 1'b0;
      end
      DONE: begin
        IF_Done = !owner_d;
        D_Done  = owner_d;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_ctrl
//  Purpose  : Self-checking bench for mem_access_ctrl at WAIT_CYCLES 1, 2, 15.
//             Each access is modelled as a phase count since the grant.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int NI = 3;

  logic Clk = 1'b0;
  logic Reset;
  logic IF_Req;
  logic D_Req;
  logic D_WE;

  // Per instance: {IF_Done, D_Done, ADDR_Sel, LD_MAR, LD_MDR, MIO_EN, OE_N, WE_N, Busy}
  wire [NI-1:0][8:0] obs;

  always #5 Clk = ~Clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_access_ctrl #(
        .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 2 : 15))
      ) u_dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .IF_Req   (IF_Req),
        .D_Req    (D_Req),
        .D_WE     (D_WE),
        .IF_Done  (obs[g][8]),
        .D_Done   (obs[g][7]),
        .ADDR_Sel (obs[g][6]),
        .LD_MAR   (obs[g][5]),
        .LD_MDR   (obs[g][4]),
        .MIO_EN   (obs[g][3]),
        .Mem_OE_N (obs[g][2]),
        .Mem_WE_N (obs[g][1]),
        .Busy     (obs[g][0])
      );
    end
  endgenerate

  // Reference model: phase 0 = idle, 1 = address, 2..W+1 = strobe, W+2 = done
  int   wc     [NI];
  int   phase  [NI];
  logic owner  [NI];
  logic mwe    [NI];
  logic pref_d [NI];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%b exp=%b", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      phase[i]  = 0;
      owner[i]  = 1'b0;
      mwe[i]    = 1'b0;
      pref_d[i] = 1'b1;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      if (phase[i] == 0) begin
        if (IF_Req || D_Req) begin
          owner[i]  = D_Req && (!IF_Req || pref_d[i]);
          mwe[i]    = owner[i] && D_WE;
          pref_d[i] = !owner[i];
          phase[i]  = 1;
        end
      end else if (phase[i] == wc[i] + 2) begin
        phase[i] = 0;
      end else begin
        phase[i] = phase[i] + 1;
      end
    end
  endtask

  function automatic logic [8:0] expv(input int i);
    int   p;
    int   w;
    logic strobe;
    logic last;
    p      = phase[i];
    w      = wc[i];
    strobe = (p >= 2) && (p <= w + 1);
    last   = (p == w + 1);
    expv[8] = (p == w + 2) && !owner[i];
    expv[7] = (p == w + 2) && owner[i];
    expv[6] = owner[i];
    expv[5] = (p == 1);
    expv[4] = ((p == 1) && mwe[i]) || (last && !mwe[i]);
    expv[3] = last && !mwe[i];
    expv[2] = !(strobe && !mwe[i]);
    expv[1] = !(strobe && mwe[i]);
    expv[0] = (p != 0);
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < NI; i++)
      check($sformatf("%s[W=%0d,ph=%0d]", tag, wc[i], phase[i]), obs[i], expv(i));
  endtask

  task automatic cycle(input string tag);
    @(posedge Clk);
    if (Reset) model_reset();
    else model_step();
    @(negedge Clk);
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  initial begin
    wc[0] = 1;
    wc[1] = 2;
    wc[2] = 15;
    model_reset();
    Reset  = 1'b1;
    IF_Req = 1'b0;
    D_Req  = 1'b0;
    D_WE   = 1'b0;
    #1;
    check_all("reset");
    run("reset_hold", 2);
    Reset = 1'b0;

    // Both requesters held from reset release: D first, then alternation
    IF_Req = 1'b1;
    D_Req  = 1'b1;
    D_WE   = 1'b0;
    run("both_held", 45);
    IF_Req = 1'b0;
    D_Req  = 1'b0;
    run("drain", 20);

    // Fetch-only reads, held high so each Done is followed by a new access
    IF_Req = 1'b1;
    D_WE   = 1'b1;
    run("if_read", 24);
    IF_Req = 1'b0;
    run("drain", 20);

    // Data-side writes
    D_Req = 1'b1;
    D_WE  = 1'b1;
    run("d_write", 24);
    D_Req = 1'b0;
    run("drain", 20);

    // Data read with the request dropped in the strobe phase
    D_Req = 1'b1;
    D_WE  = 1'b0;
    run("d_read_drop", 3);
    D_Req = 1'b0;
    run("after_drop", 22);

    // Asynchronous reset in the first write-strobe cycle
    D_Req = 1'b1;
    D_WE  = 1'b1;
    run("wr_abort", 2);
    #2 Reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    D_Req = 1'b0;
    run("abort_hold", 1);
    Reset  = 1'b0;
    IF_Req = 1'b1;
    run("if_after_reset", 20);
    IF_Req = 1'b0;
    run("drain", 20);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      IF_Req = ($urandom_range(0, 99) < 45);
      D_Req  = ($urandom_range(0, 99) < 45);
      D_WE   = $urandom_range(0, 1) == 1;
      cycle("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, number of cycles the SRAM strobe is held (legal 1..15).
REQ-002 SHALL have port Clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port IF_Req  input  1  fetch-side read request (level).
REQ-005 SHALL have port D_Req  input  1  data-side access request (level).
REQ-006 SHALL have port D_WE  input  1  data-side direction: 1 write, 0 read; sampled with D_Req.
REQ-007 SHALL have ports IF_Done, D_Done  output  1 each  one-cycle completion pulse to the owning requester.
REQ-008 SHALL have port ADDR_Sel  output  1  MAR source select: 0 fetch address, 1 data address; held for the whole access.
REQ-009 SHALL have ports LD_MAR, LD_MDR, MIO_EN  output  1 each  load/select strobes to the MAR and MDR units.
REQ-010 SHALL have ports Mem_OE_N, Mem_WE_N  output  1 each  active-low SRAM output-enable and write-enable.
REQ-011 SHALL have port Busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, ADDR, RD_WAIT, WR_WAIT, DONE; all outputs decoded from registered state, owner, direction and counter only.
REQ-013 In IDLE with any request asserted, SHALL latch owner (and D_WE if owner is D) and go to ADDR next edge; no request keeps IDLE.
REQ-014 Arbitration: only D_Req -> D; only IF_Req -> IF; both -> port that did not win the previous grant (round-robin pointer, updated at each grant).
REQ-015 IF port accesses are always reads; D_WE is ignored when owner is IF.
REQ-016 ADDR (1 cycle): LD_MAR=1, ADDR_Sel=owner; for a write also LD_MDR=1, MIO_EN=0 (MDR loads bus write data); for a read LD_MDR=0.
REQ-017 Read: ADDR -> RD_WAIT; RD_WAIT lasts exactly WAIT_CYCLES cycles with Mem_OE_N=0; in its final cycle only, LD_MDR=1 and MIO_EN=1.
REQ-018 Write: ADDR -> WR_WAIT; WR_WAIT lasts exactly WAIT_CYCLES cycles with Mem_WE_N=0, Mem_OE_N=1.
REQ-019 Mem_OE_N and Mem_WE_N SHALL never be low in the same cycle; both high in IDLE, ADDR, DONE.
REQ-020 Wait counter 4 bits, loaded WAIT_CYCLES-1 on entering a wait state, decremented each cycle, exit when 0; no wrap.
REQ-021 DONE (1 cycle): owner's Done=1, other Done=0, then unconditionally IDLE; requests ignored in DONE.
REQ-022 Latency: Done is asserted WAIT_CYCLES+2 cycles after the IDLE edge that sampled the request; back-to-back accesses separated by exactly one IDLE cycle.
REQ-023 Requester SHALL hold Req and its address/data stable until Done; Req deasserted mid-access is ignored and the access completes.
REQ-024 Req still high in the IDLE cycle after Done is treated as a new request.
REQ-025 MIO_EN=0 and LD_MDR=0 in every cycle not named in REQ-016/REQ-017; ADDR_Sel holds last owner in IDLE.

Reset
REQ-026 Reset SHALL asynchronously force IDLE, counter 0, owner IF, ADDR_Sel=0, round-robin pointer favouring D, all strobes/Done/Busy 0, Mem_OE_N=Mem_WE_N=1.
REQ-027 Reset asserted mid-access SHALL abort it immediately (strobes released same cycle, no Done pulse); first request after release arbitrated per REQ-026 pointer.

Verification
REQ-028 WAIT_CYCLES=2, IF_Req only -> ADDR: LD_MAR=1,ADDR_Sel=0; 2 cycles OE_N=0 with LD_MDR=MIO_EN=1 in 2nd; IF_Done 4 cycles after sample.
REQ-029 D_Req=1,D_WE=1 -> ADDR: LD_MAR=LD_MDR=1,MIO_EN=0,ADDR_Sel=1; 2 cycles WE_N=0,OE_N=1; D_Done pulse; OE_N never low.
REQ-030 IF_Req and D_Req held high from reset release -> grants D, IF, D, IF alternating; each Done one cycle, one IDLE cycle between accesses.
REQ-031 Reset asserted during 1st WR_WAIT cycle -> WE_N high and Busy 0 without clock edge, no D_Done; next IF-only request completes normally.
REQ-032 WAIT_CYCLES=1 and 15 read -> OE_N low exactly 1/15 cycles, Done at 3/17 cycles after sample.
REQ-033 D_Req dropped during RD_WAIT -> access completes, D_Done pulses, controller returns to IDLE and stays there.
